gcm_out_axis_tx: RTL and testbench
==================================

// Module: gcm_out_axis_tx
// PURPOSE
//  Output side of the GCM datapath: accepts 128-bit result blocks (ciphertext/plaintext, then tag) from gcm
//  via gcm_out_blk/gcm_out_store_blk and drives controller_out_ready as backpressure. Buffers blocks in a small
//  FIFO and serialises each block into 32-bit AXI-Stream beats toward the DMA, asserting tlast on the final
//  beat of a GCM operation. It is the counterpart of the input feeder that pushes blocks via gcm_valid/gcm_ready.
// PARAMETERS
//  GCM_BLK_BITS  128  block width; must equal 4*AXIS_DATA_BITS
//  AXIS_DATA_BITS 32  stream beat width
//  FIFO_DEPTH     4   block entries; power of two, >=2
// PORTS
//  clk                 in   1    clock
//  reset               in   1    asynchronous, active-low reset
//  gcm_out_blk         in   128  result block from gcm
//  gcm_out_store_blk   in   1    block valid this cycle (single-cycle strobe)
//  gcm_done            in   1    operation complete; coincides with the final store strobe (tag block)
//  controller_out_ready out 1    high = FIFO can accept a block this cycle
//  m_axis_tdata        out  32   stream data
//  m_axis_tvalid       out  1    stream valid
//  m_axis_tlast        out  1    last beat of an operation
//  m_axis_tready       in   1    stream ready from DMA
//  overflow_err        out  1    sticky: store strobe arrived while FIFO full
//  busy                out  1    FIFO non-empty or beat in progress
// BEHAVIOUR
//  - Reset (reset==0, async): FIFO empty, wr/rd ptrs=0, beat_cnt=0, overflow_err=0; hence tvalid=0, tlast=0,
//    tdata=0, busy=0, controller_out_ready=1 once reset deasserts.
//  - controller_out_ready = !full (combinational from count; a same-cycle pop does NOT free a slot).
//  - Write: gcm_out_store_blk && !full -> store {last=gcm_done, blk} at wr_ptr, wr_ptr++ (wraps mod FIFO_DEPTH).
//    Store while full -> block dropped, FIFO unchanged, overflow_err<=1 (cleared only by reset).
//    gcm_done without store strobe -> ignored.
//  - Latency: block stored at edge N -> tvalid=1 with beat 0 from the cycle after edge N (1 cycle).
//  - Serialise: tvalid = !empty; beat order MSW first: beat k drives blk[127-32k -: 32], k=beat_cnt 0..3.
//    tdata/tvalid/tlast held stable while tvalid && !tready (AXIS rule). tdata=0 when empty.
//  - Handshake: tvalid&&tready -> beat_cnt++; on beat 3 beat_cnt->0 and head entry popped (rd_ptr++ wraps).
//  - tlast = entry.last && beat_cnt==3; only on that beat.
//  - Simultaneous push+pop: both take effect, count unchanged; push+pop when full: pop only (ready was 0).
//  - count width clog2(FIFO_DEPTH)+1; full = count==FIFO_DEPTH, empty = count==0.
//  - busy = !empty.
//  - Back-to-back: with tready held 1, one block drains every 4 cycles; gcm stalls via controller_out_ready.
// CONFIGURATION
//  GCM_OUT_BSWAP_EN defined: each 32-bit beat is byte-reversed (tdata = {b0,b1,b2,b3} of the selected word)
//  for little-endian DMA memory layout. Undefined: word passed unmodified. Beat order and tlast unaffected.
// TESTING
//  1 Reset: hold reset=0 -> tvalid=0, tlast=0, overflow_err=0, busy=0; release -> controller_out_ready=1.
//  2 Single block 0x00112233_44556677_8899AABB_CCDDEEFF with gcm_done=1, tready=1 -> beats 0x00112233,
//    0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles starting 1 cycle after store; tlast on 4th only.
//  3 Fill: tready=0, 4 stores -> controller_out_ready=0 after 4th; 5th store -> overflow_err=1, 4 blocks
//    later emerge intact in order, none duplicated.
//  4 Backpressure: random tready (50%) over 3-block op (2 data + tag) -> 12 beats in order, tdata stable
//    while stalled, exactly one tlast on beat 12.
//  5 Push on the cycle head pops (full FIFO) -> no write; push with count=3 during pop -> accepted, count=3.
//  6 With GCM_OUT_BSWAP_EN, block from test 2 -> beats 0x33221100, 0x77665544, 0xBBAA9988, 0xFFEEDDCC.

Source files
------------

// File: rtl/gcm_out_axis_tx.sv
// rtl/gcm_out_axis_tx.sv - GCM result block FIFO serialised into 32-bit AXI-Stream beats
// Optional GCM_OUT_BSWAP_EN: byte-reverse each beat for little-endian DMA layout.
module gcm_out_axis_tx #(
    parameter int GCM_BLK_BITS   = 128,
    parameter int AXIS_DATA_BITS = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GCM_BLK_BITS-1:0]   gcm_out_blk,
    input  logic                      gcm_out_store_blk,
    input  logic                      gcm_done,
    output logic                      controller_out_ready,
    output logic [AXIS_DATA_BITS-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic                      overflow_err,
    output logic                      busy
);

    localparam int BEATS  = GCM_BLK_BITS / AXIS_DATA_BITS;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int NBYTES = AXIS_DATA_BITS / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [GCM_BLK_BITS-1:0] mem_blk_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   mem_last_q;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              overflow_q, overflow_d;

    logic                      full, empty, push, pop, handshake;
    logic [GCM_BLK_BITS-1:0]   head_blk;
    logic                      head_last;
    logic [AXIS_DATA_BITS-1:0] beat_word, out_word;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign head_blk  = mem_blk_q[rd_ptr_q];
    assign head_last = mem_last_q[rd_ptr_q];

    // A pop in the same cycle does not open a slot: ready depends on count only.
    assign push      = gcm_out_store_blk && !full;
    assign handshake = !empty && m_axis_tready;
    assign pop       = handshake && (beat_cnt_q == LAST_BEAT);

    always_comb begin
        beat_word = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_cnt_q == BEAT_W'(k)) begin
                beat_word = head_blk[GCM_BLK_BITS-1-k*AXIS_DATA_BITS -: AXIS_DATA_BITS];
            end
        end
    end

`ifdef GCM_OUT_BSWAP_EN
    always_comb begin
        out_word = '0;
        for (int b = 0; b < NBYTES; b++) begin
            out_word[8*b +: 8] = beat_word[AXIS_DATA_BITS-8-8*b +: 8];
        end
    end
`else
    assign out_word = beat_word;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        beat_cnt_d = beat_cnt_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (gcm_out_store_blk && full) begin
            overflow_d = 1'b1;
        end
        if (handshake) begin
            beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + BEAT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            beat_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            beat_cnt_q <= beat_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: nothing is read out while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_blk_q[wr_ptr_q]  <= gcm_out_blk;
            mem_last_q[wr_ptr_q] <= gcm_done;
        end
    end

    assign controller_out_ready = !full;
    assign m_axis_tvalid        = !empty;
    assign m_axis_tdata         = empty ? '0 : out_word;
    assign m_axis_tlast         = !empty && head_last && (beat_cnt_q == LAST_BEAT);
    assign overflow_err         = overflow_q;
    assign busy                 = !empty;

endmodule

// File: tb/tb_gcm_out_axis_tx.sv
// tb/tb_gcm_out_axis_tx.sv - scoreboard bench for gcm_out_axis_tx
module tb_gcm_out_axis_tx;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] gcm_out_blk;
    logic         gcm_out_store_blk;
    logic         gcm_done;
    logic         controller_out_ready;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic         overflow_err;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb [$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    always #5 clk = ~clk;

    gcm_out_axis_tx dut (
        .clk                  (clk),
        .reset                (reset),
        .gcm_out_blk          (gcm_out_blk),
        .gcm_out_store_blk    (gcm_out_store_blk),
        .gcm_done             (gcm_done),
        .controller_out_ready (controller_out_ready),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_tready        (m_axis_tready),
        .overflow_err         (overflow_err),
        .busy                 (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [127:0] blk, input int k);
        logic [31:0] w;
        w = blk[127-32*k -: 32];
`ifdef GCM_OUT_BSWAP_EN
        w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [127:0] blk, input logic done, input logic acc);
        chk("ready_before_store", {127'd0, controller_out_ready}, {127'd0, acc});
        if (acc) begin
            for (int k = 0; k < 4; k++) sb.push_back({done && (k == 3), exp_word(blk, k)});
        end
        gcm_out_blk       = blk;
        gcm_done          = done;
        gcm_out_store_blk = 1'b1;
        cyc();
        gcm_out_store_blk = 1'b0;
        gcm_done          = 1'b0;
    endtask

    task automatic drain(input int max_cycles, input logic random_ready);
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0 && !busy) break;
            m_axis_tready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
        end
        m_axis_tready = 1'b1;
        chk("drain_sb_empty", 128'(sb.size()), 128'd0);
        chk("drain_busy", {127'd0, busy}, 128'd0);
    endtask

    // Beat monitor: mid-cycle sample, compares handshaken beats and AXIS stability.
    always @(negedge clk) begin
        if (reset) begin
            if (prev_stall) begin
                chk("stall_tvalid", {127'd0, m_axis_tvalid}, 128'd1);
                chk("stall_tdata", {96'd0, m_axis_tdata}, {96'd0, prev_data});
                chk("stall_tlast", {127'd0, m_axis_tlast}, {127'd0, prev_last});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {95'd0, m_axis_tlast, m_axis_tdata}, 128'd0);
                end else begin
                    logic [32:0] e;
                    e = sb.pop_front();
                    chk("beat_tdata", {96'd0, m_axis_tdata}, {96'd0, e[31:0]});
                    chk("beat_tlast", {127'd0, m_axis_tlast}, {127'd0, e[32]});
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] b2;
        logic [127:0] blk;
        b2 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

        reset             = 1'b0;
        gcm_out_blk       = '0;
        gcm_out_store_blk = 1'b0;
        gcm_done          = 1'b0;
        m_axis_tready     = 1'b0;

        // 1: reset state
        repeat (3) cyc();
        chk("rst_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
        chk("rst_tlast", {127'd0, m_axis_tlast}, 128'd0);
        chk("rst_tdata", {96'd0, m_axis_tdata}, 128'd0);
        chk("rst_overflow", {127'd0, overflow_err}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        reset = 1'b1;
        cyc();
        chk("rst_ready", {127'd0, controller_out_ready}, 128'd1);

        // 2: single block, one-cycle latency, four consecutive beats
        m_axis_tready = 1'b1;
        store(b2, 1'b1, 1'b1);
        chk("lat_tvalid", {127'd0, m_axis_tvalid}, 128'd1);
`ifdef GCM_OUT_BSWAP_EN
        chk("lat_tdata", {96'd0, m_axis_tdata}, {96'd0, 32'h33221100});
`else
        chk("lat_tdata", {96'd0, m_axis_tdata}, {96'd0, 32'h00112233});
`endif
        repeat (4) cyc();
        chk("t2_sb_empty", 128'(sb.size()), 128'd0);
        chk("t2_busy", {127'd0, busy}, 128'd0);

        // 3: fill with tready low, then overflow on the 5th store
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            blk = {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i),
                   32'h3000_0000 + 32'(i), 32'h4000_0000 + 32'(i)};
            store(blk, i == 3, 1'b1);
        end
        chk("full_ready", {127'd0, controller_out_ready}, 128'd0);
        chk("full_no_overflow", {127'd0, overflow_err}, 128'd0);
        store(128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 1'b1, 1'b0);
        chk("overflow_set", {127'd0, overflow_err}, 128'd1);
        drain(40, 1'b0);
        chk("overflow_sticky", {127'd0, overflow_err}, 128'd1);

        // 4: random backpressure over a 3-block operation
        for (int i = 0; i < 3; i++) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            blk = {$urandom, $urandom, $urandom, $urandom};
            store(blk, i == 2, 1'b1);
        end
        drain(400, 1'b1);

        // 5: push on the pop cycle of a full FIFO is refused; push at count=3 during pop accepted
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            blk = {32'h5000_0000 + 32'(i), 32'h6000_0000 + 32'(i),
                   32'h7000_0000 + 32'(i), 32'h8000_0000 + 32'(i)};
            store(blk, 1'b0, 1'b1);
        end
        m_axis_tready = 1'b1;
        repeat (3) cyc();
        store(128'hBAD0_0000_BAD0_0001_BAD0_0002_BAD0_0003, 1'b0, 1'b0);
        chk("after_pop_ready", {127'd0, controller_out_ready}, 128'd1);
        repeat (3) cyc();
        store(128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004, 1'b1, 1'b1);
        chk("pushpop_ready", {127'd0, controller_out_ready}, 128'd1);
        chk("pushpop_busy", {127'd0, busy}, 128'd1);
        drain(60, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
